sarseq: RTL and testbench

//  Parametrised multi-channel SAR ADC sequencer: successor to the 8-bit DAC mux/SAR cycle logic.

---
 rtl/sarseq.sv | 265 ++++++++++++++++++++++++++
 tb/tb_sarseq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sarseq.sv
// Multi-channel SAR ADC sequencer: scans enabled channels through S/H reset, sample and
// successive-approximation trials. Optional averaging is enabled by defining SARSEQ_AVG_EN.
module sarseq #(
   parameter int unsigned N_CHNL  = 18,
   parameter int unsigned BIT_PTR = 5,
   parameter int unsigned N_BIT   = 10
) (
   input  logic               clk,
   input  logic               srstz,
   input  logic               i_comp,
   input  logic [N_CHNL-1:0]  r_ch_en,
   input  logic               r_start,
   input  logic               r_stop,
   input  logic               r_loop,
   input  logic [3:0]         r_smpl_t,
   input  logic [1:0]         r_settle_t,
   input  logic [1:0]         r_avg,
   input  logic [N_BIT-1:0]   r_thr_lo,
   input  logic [N_BIT-1:0]   r_thr_hi,
   input  logic [N_CHNL-1:0]  i_sta_clr,
   output logic               o_shrst,
   output logic               o_hold,
   output logic [N_CHNL-1:0]  o_daci_sel,
   output logic [N_BIT-1:0]   o_dac,
   output logic               o_busy,
   output logic               o_rslt_vld,
   output logic [BIT_PTR-1:0] o_rslt_ch,
   output logic [N_BIT-1:0]   o_rslt,
   output logic [N_CHNL-1:0]  o_wsta,
   output logic               o_intr
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned BIT_W = $clog2(N_BIT);
`ifdef SARSEQ_AVG_EN
   localparam int unsigned ACC_W = N_BIT + 3;
   localparam int unsigned AVG_W = 4;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHRST,
      S_SAMPLE,
      S_TRIAL,
      S_DONE
   } state_e;

   state_e               state_q, state_d;
   logic [BIT_PTR-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [N_BIT-1:0]     sar_q, sar_d;
   logic                 comp_s1_q, comp_s2_q;
   logic                 shrst_q, shrst_d;
   logic                 hold_q, hold_d;
   logic [N_CHNL-1:0]    sel_q, sel_d;
   logic [N_BIT-1:0]     dac_q, dac_d;
   logic                 busy_q, busy_d;
   logic                 vld_q, vld_d;
   logic [BIT_PTR-1:0]   rslt_ch_q, rslt_ch_d;
   logic [N_BIT-1:0]     rslt_q, rslt_d;
   logic [N_CHNL-1:0]    wsta_q, wsta_d;
   logic                 intr_q, intr_d;

   logic [N_CHNL-1:0]    wsta_set;
   logic [N_BIT-1:0]     rslt_fin;
   logic                 last_conv;
   logic [BIT_PTR-1:0]   nxt_ch, low_ch;
   logic                 nxt_found, low_found;

`ifdef SARSEQ_AVG_EN
   logic [ACC_W-1:0]     acc_q, acc_d, acc_sum;
   logic [AVG_W-1:0]     avg_cnt_q, avg_cnt_d;
`else
   logic                 unused_avg;
   assign unused_avg = ^r_avg;
`endif

   // Lowest enabled channel overall and lowest enabled channel above the pointer
   always_comb begin
      nxt_ch    = '0;
      nxt_found = 1'b0;
      low_ch    = '0;
      low_found = 1'b0;
      for (int i = int'(N_CHNL) - 1; i >= 0; i--) begin
         if (r_ch_en[i]) begin
            low_ch    = BIT_PTR'(i);
            low_found = 1'b1;
            if (i > int'(ptr_q)) begin
               nxt_ch    = BIT_PTR'(i);
               nxt_found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      sar_d     = sar_q;
      vld_d     = 1'b0;
      rslt_d    = rslt_q;
      rslt_ch_d = rslt_ch_q;
      wsta_set  = '0;
      rslt_fin  = sar_q;
      last_conv = 1'b1;
`ifdef SARSEQ_AVG_EN
      acc_d     = acc_q;
      avg_cnt_d = avg_cnt_q;
      acc_sum   = acc_q + ACC_W'(sar_q);
`endif

      case (state_q)
         S_IDLE: begin
            if (r_start && low_found) begin
               state_d = S_SHRST;
               ptr_d   = low_ch;
            end
         end
         S_SHRST: begin
            state_d = S_SAMPLE;
            cnt_d   = CNT_W'(r_smpl_t);
            sar_d   = '0;
         end
         S_SAMPLE: begin
            if (cnt_q == '0) begin
               state_d = S_TRIAL;
               cnt_d   = CNT_W'(r_settle_t) + CNT_W'(2);
               bit_d   = BIT_W'(N_BIT - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_TRIAL: begin
            // Decision uses the synchronised comparator seen at the end of the trial
            if (cnt_q == '0) begin
               if (comp_s2_q) sar_d = dac_q;
               if (bit_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  bit_d = bit_q - BIT_W'(1);
                  cnt_d = CNT_W'(r_settle_t) + CNT_W'(2);
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DONE: begin
`ifdef SARSEQ_AVG_EN
            last_conv = (avg_cnt_q == ((AVG_W'(1) << r_avg) - AVG_W'(1)));
            rslt_fin  = N_BIT'(acc_sum >> r_avg);
            if (last_conv) begin
               acc_d     = '0;
               avg_cnt_d = '0;
            end else begin
               acc_d     = acc_sum;
               avg_cnt_d = avg_cnt_q + AVG_W'(1);
            end
`endif
            if (last_conv) begin
               vld_d     = 1'b1;
               rslt_d    = rslt_fin;
               rslt_ch_d = ptr_q;
               if ((rslt_fin < r_thr_lo) || (rslt_fin > r_thr_hi))
                  wsta_set = N_CHNL'(1) << ptr_q;
               if (nxt_found) begin
                  state_d = S_SHRST;
                  ptr_d   = nxt_ch;
               end else if (r_loop && low_found) begin
                  state_d = S_SHRST;
                  ptr_d   = low_ch;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_SHRST;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort beats everything, including a same-cycle start or result
      if (r_stop) begin
         state_d   = S_IDLE;
         vld_d     = 1'b0;
         rslt_d    = rslt_q;
         rslt_ch_d = rslt_ch_q;
         wsta_set  = '0;
`ifdef SARSEQ_AVG_EN
         acc_d     = '0;
         avg_cnt_d = '0;
`endif
      end

      shrst_d = (state_d == S_SHRST);
      hold_d  = (state_d == S_TRIAL);
      sel_d   = (state_d inside {S_SHRST, S_SAMPLE, S_TRIAL}) ? (N_CHNL'(1) << ptr_d) : '0;
      dac_d   = (state_d == S_TRIAL) ? (sar_d | (N_BIT'(1) << bit_d)) : '0;
      busy_d  = (state_d != S_IDLE) || vld_d;
      wsta_d  = (wsta_q & ~i_sta_clr) | wsta_set;
      intr_d  = |wsta_d;
   end

   always_ff @(posedge clk or negedge srstz) begin
      if (!srstz) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         cnt_q     <= '0;
         bit_q     <= '0;
         sar_q     <= '0;
         comp_s1_q <= 1'b0;
         comp_s2_q <= 1'b0;
         shrst_q   <= 1'b0;
         hold_q    <= 1'b0;
         sel_q     <= '0;
         dac_q     <= '0;
         busy_q    <= 1'b0;
         vld_q     <= 1'b0;
         rslt_ch_q <= '0;
         rslt_q    <= '0;
         wsta_q    <= '0;
         intr_q    <= 1'b0;
`ifdef SARSEQ_AVG_EN
         acc_q     <= '0;
         avg_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         sar_q     <= sar_d;
         comp_s1_q <= i_comp;
         comp_s2_q <= comp_s1_q;
         shrst_q   <= shrst_d;
         hold_q    <= hold_d;
         sel_q     <= sel_d;
         dac_q     <= dac_d;
         busy_q    <= busy_d;
         vld_q     <= vld_d;
         rslt_ch_q <= rslt_ch_d;
         rslt_q    <= rslt_d;
         wsta_q    <= wsta_d;
         intr_q    <= intr_d;
`ifdef SARSEQ_AVG_EN
         acc_q     <= acc_d;
         avg_cnt_q <= avg_cnt_d;
`endif
      end
   end

   assign o_shrst    = shrst_q;
   assign o_hold     = hold_q;
   assign o_daci_sel = sel_q;
   assign o_dac      = dac_q;
   assign o_busy     = busy_q;
   assign o_rslt_vld = vld_q;
   assign o_rslt_ch  = rslt_ch_q;
   assign o_rslt     = rslt_q;
   assign o_wsta     = wsta_q;
   assign o_intr     = intr_q;

endmodule

// File: tb/tb_sarseq.sv
// Directed bench for sarseq with an ideal comparator model (Vin >= DAC code).
module tb_sarseq;

   logic        clk = 1'b0;
   logic        srstz;
   logic        i_comp;
   logic [17:0] r_ch_en;
   logic        r_start, r_stop, r_loop;
   logic [3:0]  r_smpl_t;
   logic [1:0]  r_settle_t, r_avg;
   logic [9:0]  r_thr_lo, r_thr_hi;
   logic [17:0] i_sta_clr;
   logic        o_shrst, o_hold, o_busy, o_rslt_vld, o_intr;
   logic [17:0] o_daci_sel, o_wsta;
   logic [9:0]  o_dac, o_rslt;
   logic [4:0]  o_rslt_ch;

   logic [9:0]  vin;
   int          n_chk = 0;
   int          n_err = 0;
   int          cycle = 0;
   int          t_start = 0;

   sarseq #(.N_CHNL(18), .BIT_PTR(5), .N_BIT(10)) dut (
      .clk(clk), .srstz(srstz), .i_comp(i_comp), .r_ch_en(r_ch_en),
      .r_start(r_start), .r_stop(r_stop), .r_loop(r_loop),
      .r_smpl_t(r_smpl_t), .r_settle_t(r_settle_t), .r_avg(r_avg),
      .r_thr_lo(r_thr_lo), .r_thr_hi(r_thr_hi), .i_sta_clr(i_sta_clr),
      .o_shrst(o_shrst), .o_hold(o_hold), .o_daci_sel(o_daci_sel), .o_dac(o_dac),
      .o_busy(o_busy), .o_rslt_vld(o_rslt_vld), .o_rslt_ch(o_rslt_ch),
      .o_rslt(o_rslt), .o_wsta(o_wsta), .o_intr(o_intr)
   );

   always #5 clk = ~clk;

   assign i_comp = (vin >= o_dac);

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cycle++;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_scan();
      t_start = cycle;
      r_start = 1'b1;
      tick(1);
      r_start = 1'b0;
   endtask

   task automatic wait_vld(input string tag, input int budget);
      int n;
      n = 0;
      while (o_rslt_vld !== 1'b1 && n < budget) begin
         tick(1);
         n++;
      end
      chk({tag, "_seen"}, 32'(o_rslt_vld), 32'd1);
   endtask

   initial begin
      int nvld;
      srstz = 1'b0; r_ch_en = '0; r_start = 1'b0; r_stop = 1'b0; r_loop = 1'b0;
      r_smpl_t = 4'd3; r_settle_t = 2'd0; r_avg = 2'd0;
      r_thr_lo = 10'h100; r_thr_hi = 10'h300; i_sta_clr = '0; vin = 10'h2A5;
      tick(2);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_sel", 32'(o_daci_sel), 0);
      chk("rst_dac", 32'(o_dac), 0);
      chk("rst_vld", 32'(o_rslt_vld), 0);
      chk("rst_wsta", 32'(o_wsta), 0);
      chk("rst_shrst", 32'(o_shrst), 0);
      srstz = 1'b1;
      tick(2);

      // Single conversion on ch2, Vin=0x2A5
      r_ch_en = 18'h4;
      start_scan();
      chk("t1_shrst", 32'(o_shrst), 1);
      chk("t1_sel", 32'(o_daci_sel), 32'h4);
      chk("t1_busy", 32'(o_busy), 1);
      tick(1);
      chk("t1_smp_shrst", 32'(o_shrst), 0);
      chk("t1_smp_dac", 32'(o_dac), 0);
      tick(4);
      chk("t1_trial_hold", 32'(o_hold), 1);
      chk("t1_trial_dac", 32'(o_dac), 32'h200);
      wait_vld("t1", 100);
      chk("t1_latency", 32'(cycle - t_start), 37);
      chk("t1_rslt", 32'(o_rslt), 32'h2A5);
      chk("t1_ch", 32'(o_rslt_ch), 2);
      chk("t1_busy_at_vld", 32'(o_busy), 1);
      tick(1);
      chk("t1_vld_drop", 32'(o_rslt_vld), 0);
      chk("t1_busy_drop", 32'(o_busy), 0);
      chk("t1_rslt_hold", 32'(o_rslt), 32'h2A5);
      chk("t1_sel_idle", 32'(o_daci_sel), 0);

      // Looping scan ch0/ch2, then abort mid-trial
      vin = 10'h155; r_ch_en = 18'h5; r_loop = 1'b1;
      start_scan();
      wait_vld("lp0", 100);
      chk("lp0_ch", 32'(o_rslt_ch), 0);
      chk("lp0_rslt", 32'(o_rslt), 32'h155);
      tick(1);
      wait_vld("lp1", 100);
      chk("lp1_ch", 32'(o_rslt_ch), 2);
      tick(1);
      wait_vld("lp2", 100);
      chk("lp2_ch", 32'(o_rslt_ch), 0);
      tick(10);
      chk("lp_mid_hold", 32'(o_hold), 1);
      chk("lp_mid_sel", 32'(o_daci_sel), 32'h4);
      r_stop = 1'b1;
      tick(1);
      r_stop = 1'b0;
      r_loop = 1'b0;
      chk("stop_busy", 32'(o_busy), 0);
      chk("stop_dac", 32'(o_dac), 0);
      chk("stop_sel", 32'(o_daci_sel), 0);
      chk("stop_vld", 32'(o_rslt_vld), 0);
      nvld = 0;
      for (int k = 0; k < 50; k++) begin
         if (o_rslt_vld) nvld++;
         tick(1);
      end
      chk("stop_no_strobe", 32'(nvld), 0);
      chk("stop_wsta", 32'(o_wsta), 0);

      // Out-of-window below threshold on ch1
      vin = 10'h0FF; r_ch_en = 18'h2;
      start_scan();
      wait_vld("win", 100);
      chk("win_rslt", 32'(o_rslt), 32'h0FF);
      chk("win_wsta", 32'(o_wsta), 32'h2);
      chk("win_intr", 32'(o_intr), 1);
      tick(2);
      start_scan();
      tick(35);
      i_sta_clr = 18'h2;
      tick(1);
      i_sta_clr = '0;
      chk("clr_vld", 32'(o_rslt_vld), 1);
      chk("clr_set_wins", 32'(o_wsta), 32'h2);
      tick(1);
      i_sta_clr = 18'h2;
      tick(1);
      i_sta_clr = '0;
      chk("clr_wsta", 32'(o_wsta), 0);
      chk("clr_intr", 32'(o_intr), 0);

      // End codes
      vin = 10'h000; r_ch_en = 18'h8;
      start_scan();
      wait_vld("zero", 100);
      chk("zero_rslt", 32'(o_rslt), 0);
      chk("zero_ch", 32'(o_rslt_ch), 3);
      tick(2);
      vin = 10'h3FF; r_ch_en = 18'h20000;
      start_scan();
      wait_vld("full", 100);
      chk("full_rslt", 32'(o_rslt), 32'h3FF);
      chk("full_ch", 32'(o_rslt_ch), 17);
      chk("full_wsta", 32'(o_wsta), 32'h20008);
      tick(2);

      // Different timing: smpl_t=0, settle_t=1
      vin = 10'h12C; r_ch_en = 18'h20; r_smpl_t = 4'd0; r_settle_t = 2'd1;
      start_scan();
      wait_vld("lat2", 100);
      chk("lat2_latency", 32'(cycle - t_start), 44);
      chk("lat2_rslt", 32'(o_rslt), 32'h12C);
      chk("lat2_ch", 32'(o_rslt_ch), 5);
      tick(2);
      r_smpl_t = 4'd3; r_settle_t = 2'd0;

      // Starts that must be ignored
      r_ch_en = '0;
      start_scan();
      chk("noen_busy", 32'(o_busy), 0);
      tick(3);
      chk("noen_busy2", 32'(o_busy), 0);
      r_ch_en = 18'h1; r_stop = 1'b1;
      start_scan();
      r_stop = 1'b0;
      chk("stop_start_busy", 32'(o_busy), 0);
      chk("stop_start_sel", 32'(o_daci_sel), 0);

      // Async reset mid-sample, then a fresh conversion
      r_ch_en = 18'h4; vin = 10'h3C3;
      start_scan();
      tick(2);
      chk("ar_sel_before", 32'(o_daci_sel), 32'h4);
      #2 srstz = 1'b0;
      #1;
      chk("ar_busy", 32'(o_busy), 0);
      chk("ar_sel", 32'(o_daci_sel), 0);
      chk("ar_wsta", 32'(o_wsta), 0);
      chk("ar_rslt", 32'(o_rslt), 0);
      chk("ar_intr", 32'(o_intr), 0);
      tick(1);
      srstz = 1'b1;
      tick(1);
      start_scan();
      wait_vld("ar2", 100);
      chk("ar2_latency", 32'(cycle - t_start), 37);
      chk("ar2_rslt", 32'(o_rslt), 32'h3C3);
      chk("ar2_wsta", 32'(o_wsta), 32'h4);
      tick(2);

`ifdef SARSEQ_AVG_EN
      begin
         int nsh;
         logic ph;
         nsh = 0; ph = 1'b0; r_avg = 2'd2; vin = 10'h200;
         start_scan();
         for (int k = 0; k < 400; k++) begin
            if (o_rslt_vld) break;
            if (o_shrst) begin
               vin = ph ? 10'h203 : 10'h200;
               ph  = ~ph;
               nsh++;
            end
            tick(1);
         end
         chk("avg_vld", 32'(o_rslt_vld), 1);
         chk("avg_convs", 32'(nsh), 4);
         chk("avg_rslt", 32'(o_rslt), 32'h201);
         nvld = 0;
         tick(1);
         for (int k = 0; k < 60; k++) begin
            if (o_rslt_vld) nvld++;
            tick(1);
         end
         chk("avg_one_strobe", 32'(nvld), 0);
         r_avg = 2'd0;
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
